// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state encodings, opcode class
// ranges and IR field positions, also used by the datapath and benches.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_ITYPE  = 3'd2,
        CLS_MULDIV = 3'd3,
        CLS_UNARY  = 3'd4,
        CLS_HALT   = 3'd5
    } op_class_t;

    localparam logic [4:0] OP_RTYPE_LO  = 5'b00011;
    localparam logic [4:0] OP_RTYPE_HI  = 5'b01011;
    localparam logic [4:0] OP_ITYPE_LO  = 5'b01100;
    localparam logic [4:0] OP_ITYPE_HI  = 5'b01110;
    localparam logic [4:0] OP_MULDIV_LO = 5'b01111;
    localparam logic [4:0] OP_MULDIV_HI = 5'b10000;
    localparam logic [4:0] OP_UNARY_LO  = 5'b10001;
    localparam logic [4:0] OP_UNARY_HI  = 5'b10010;
    localparam logic [4:0] OP_NOP       = 5'b11000;
    localparam logic [4:0] OP_HALT      = 5'b11001;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 27;
    localparam int unsigned RA_MSB     = 26;
    localparam int unsigned RA_LSB     = 23;
    localparam int unsigned RB_MSB     = 22;
    localparam int unsigned RB_LSB     = 19;
    localparam int unsigned RC_MSB     = 18;
    localparam int unsigned RC_LSB     = 15;

    // One-hot {Gra,Grb,Grc}
    localparam logic [2:0] GSEL_NONE = 3'b000;
    localparam logic [2:0] GSEL_RA   = 3'b100;
    localparam logic [2:0] GSEL_RB   = 3'b010;
    localparam logic [2:0] GSEL_RC   = 3'b001;

endpackage

// File: rtl/control_sequencer_opcode_classifier.sv
// Combinational opcode-to-class decode; unlisted opcodes fall back to NOP.
module control_sequencer_opcode_classifier
    import control_sequencer_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_NOP;
        if (opcode >= OP_RTYPE_LO && opcode <= OP_RTYPE_HI)
            op_class = CLS_RTYPE;
        else if (opcode >= OP_ITYPE_LO && opcode <= OP_ITYPE_HI)
            op_class = CLS_ITYPE;
        else if (opcode >= OP_MULDIV_LO && opcode <= OP_MULDIV_HI)
            op_class = CLS_MULDIV;
        else if (opcode >= OP_UNARY_LO && opcode <= OP_UNARY_HI)
            op_class = CLS_UNARY;
        else if (opcode == OP_HALT)
            op_class = CLS_HALT;
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch (T0-T2), execute (T3-T6), halt.
// Control strobes are a combinational decode of the state register and IR.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic [2:0]  gsel,
    output logic        Rin,
    output logic        Rout,
    output logic        Cout,
    output logic        RYin,
    output logic        RZinLo,
    output logic        RZinHi,
    output logic        RZoutLo,
    output logic        RZoutHi,
    output logic        LOin,
    output logic        HIin,
    output logic [4:0]  alu_op,
    output logic        run
);

    state_t     state;
    op_class_t  op_class;
    logic [4:0] opcode;
    logic       unused_ir_fields;

    assign opcode = IR[OPCODE_MSB:OPCODE_LSB];
    // Register fields are consumed by the datapath, not here.
    assign unused_ir_fields = ^{IR[RA_MSB:RA_LSB], IR[RB_MSB:RB_LSB],
                                IR[RC_MSB:RC_LSB], IR[RC_LSB-1:0]};

    control_sequencer_opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (op_class)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_RST;
        end else begin
            case (state)
                ST_RST:  state <= ST_T0;
                ST_T0:   state <= ST_T1;
                ST_T1:   if (mem_ready) state <= ST_T2;
                ST_T2: begin
                    case (op_class)
                        CLS_HALT: state <= ST_HALT;
                        CLS_NOP:  state <= ST_T0;
                        default:  state <= ST_T3;
                    endcase
                end
                ST_T3:   state <= ST_T4;
                ST_T4:   state <= ST_T5;
                ST_T5:   state <= (op_class == CLS_MULDIV) ? ST_T6 : ST_T0;
                ST_T6:   state <= ST_T0;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        gsel    = GSEL_NONE;
        Rin     = 1'b0;
        Rout    = 1'b0;
        Cout    = 1'b0;
        RYin    = 1'b0;
        RZinLo  = 1'b0;
        RZinHi  = 1'b0;
        RZoutLo = 1'b0;
        RZoutHi = 1'b0;
        LOin    = 1'b0;
        HIin    = 1'b0;
        alu_op  = '0;
        run     = (state != ST_HALT);
        case (state)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                gsel = GSEL_RB;
                Rout = 1'b1;
                RYin = 1'b1;
            end
            ST_T4: begin
                alu_op = opcode;
                RZinLo = 1'b1;
                RZinHi = (op_class == CLS_MULDIV);
                case (op_class)
                    CLS_ITYPE: Cout = 1'b1;
                    CLS_UNARY: begin
                        gsel = GSEL_RB;
                        Rout = 1'b1;
                    end
                    default: begin
                        gsel = GSEL_RC;
                        Rout = 1'b1;
                    end
                endcase
            end
            ST_T5: begin
                RZoutLo = 1'b1;
                if (op_class == CLS_MULDIV) begin
                    LOin = 1'b1;
                end else begin
                    gsel = GSEL_RA;
                    Rin  = 1'b1;
                end
            end
            ST_T6: begin
                RZoutHi = 1'b1;
                HIin    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level model expands each opcode
// into its expected per-cycle strobe pattern, checked every cycle.
module tb_control_sequencer;

    logic        clock, clear, mem_ready;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, Read, MDRin, MDRout, IRin;
    logic [2:0]  gsel;
    logic        Rin, Rout, Cout, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin;
    logic [4:0]  alu_op;
    logic        run;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .gsel(gsel), .Rin(Rin), .Rout(Rout),
        .Cout(Cout), .RYin(RYin), .RZinLo(RZinLo), .RZinHi(RZinHi),
        .RZoutLo(RZoutLo), .RZoutHi(RZoutHi), .LOin(LOin), .HIin(HIin),
        .alu_op(alu_op), .run(run)
    );

    typedef struct packed {
        logic       run;
        logic       pc_out, mar_in, inc_pc, rd, mdr_in, mdr_out, ir_in;
        logic [2:0] gsel;
        logic       rin, rout, cout, ry_in, zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in;
        logic [4:0] alu_op;
    } vec_t;

    vec_t dv;
    assign dv = {run, PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, gsel,
                 Rin, Rout, Cout, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin, alu_op};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- behavioural model ----------------
    vec_t cur;
    vec_t plan[$];
    bit   halted;

    function automatic vec_t v_base();
        vec_t v = '0;
        v.run = 1'b1;
        return v;
    endfunction
    function automatic vec_t v_fetch_addr();
        vec_t v = v_base();
        v.pc_out = 1'b1; v.mar_in = 1'b1; v.inc_pc = 1'b1;
        return v;
    endfunction
    function automatic vec_t v_read();
        vec_t v = v_base();
        v.rd = 1'b1; v.mdr_in = 1'b1;
        return v;
    endfunction
    function automatic vec_t v_decode();
        vec_t v = v_base();
        v.mdr_out = 1'b1; v.ir_in = 1'b1;
        return v;
    endfunction

    function automatic bit in_rng(input logic [4:0] op, input int lo, input int hi);
        return (int'(op) >= lo) && (int'(op) <= hi);
    endfunction

    task automatic start_fetch();
        cur = v_fetch_addr();
        plan.delete();
        plan.push_back(v_read());
        plan.push_back(v_decode());
    endtask

    task automatic expand(input logic [4:0] op);
        vec_t v;
        bit   rt, it, md, un;
        rt = in_rng(op, 3, 11);
        it = in_rng(op, 12, 14);
        md = in_rng(op, 15, 16);
        un = in_rng(op, 17, 18);
        if (op == 5'd25) begin
            cur    = '0;
            halted = 1'b1;
        end else if (!(rt || it || md || un)) begin
            start_fetch();
        end else begin
            v = v_base(); v.gsel = 3'b010; v.rout = 1'b1; v.ry_in = 1'b1;
            plan.push_back(v);
            v = v_base(); v.alu_op = op; v.zlo_in = 1'b1; v.zhi_in = md;
            if (it) v.cout = 1'b1;
            else begin
                v.rout = 1'b1;
                v.gsel = un ? 3'b010 : 3'b001;
            end
            plan.push_back(v);
            v = v_base(); v.zlo_out = 1'b1;
            if (md) v.lo_in = 1'b1;
            else begin
                v.gsel = 3'b100; v.rin = 1'b1;
            end
            plan.push_back(v);
            if (md) begin
                v = v_base(); v.zhi_out = 1'b1; v.hi_in = 1'b1;
                plan.push_back(v);
            end
            cur = plan.pop_front();
        end
    endtask

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            cur    = v_base();
            halted = 1'b0;
            plan.delete();
        end else if (halted) begin
            cur = '0;
        end else if (cur == v_read() && !mem_ready) begin
            cur = v_read();
        end else if (cur == v_decode()) begin
            expand(IR[31:27]);
        end else if (plan.size() > 0) begin
            cur = plan.pop_front();
        end else begin
            start_fetch();
        end
    end

    // ---------------- checking and stimulus ----------------
    int n_tests, n_fail;
    bit check_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic to_t0(input string name);
        int unsigned n = 0;
        do begin
            tick();
            n++;
        end while (!PCout && n < 20);
        chk(name, {31'd0, PCout}, 32'd1);
    endtask

    logic [4:0] sweep_ops [8] = '{5'b01100, 5'b10001, 5'b11000, 5'b00010,
                                  5'b10011, 5'b01110, 5'b10000, 5'b01011};

    initial begin
        int unsigned rd_cnt;
        n_tests  = 0;
        n_fail   = 0;
        check_en = 1'b0;
        clear    = 1'b1;
        IR       = '0;
        mem_ready = 1'b0;

        fork
            forever begin
                @(negedge clock);
                if (check_en) begin
                    n_tests++;
                    if (dv !== cur) begin
                        n_fail++;
                        $display("FAIL cycle_outputs: got %h, expected %h (t=%0t)", dv, cur, $time);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clock);
        #2;
        chk("reset_outputs", {6'd0, dv}, 32'h0200_0000);
        check_en = 1'b1;

        // R-type 00011, ra=4 rb=5 rc=7
        IR = 32'h1A2B_8000;
        mem_ready = 1'b1;
        clear = 1'b0;
        tick();
        chk("rst_to_t0", {31'd0, PCout}, 32'd1);
        repeat (4) tick();
        chk("t4_alu_op", {27'd0, alu_op}, 32'h03);
        chk("t4_gsel", {29'd0, gsel}, 32'h1);
        tick();
        chk("t5_gsel", {29'd0, gsel}, 32'h4);
        chk("t5_rin", {31'd0, Rin}, 32'd1);
        tick();
        chk("six_cycle_return", {31'd0, PCout}, 32'd1);

        // memory wait: three not-ready cycles in T1
        rd_cnt = 0;
        mem_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (IRin) break;
            if (Read) rd_cnt++;
            mem_ready = (rd_cnt >= 4);
            tick();
        end
        chk("read_cycles", rd_cnt, 32'd4);
        chk("irin_after_ready", {31'd0, IRin}, 32'd1);
        mem_ready = 1'b1;
        to_t0("wait_instr_done");

        // MULDIV 01111
        IR = {5'b01111, 4'd1, 4'd2, 4'd3, 15'd0};
        repeat (4) tick();
        chk("muldiv_t4_z", {30'd0, RZinLo, RZinHi}, 32'h3);
        tick();
        chk("muldiv_t5_lo", {31'd0, LOin}, 32'd1);
        tick();
        chk("muldiv_t6_hi", {31'd0, HIin}, 32'd1);
        tick();
        chk("muldiv_back_t0", {31'd0, PCout}, 32'd1);

        // illegal 11111
        IR = 32'hF800_0000;
        repeat (2) tick();
        chk("illegal_t2_irin", {31'd0, IRin}, 32'd1);
        tick();
        chk("illegal_back_t0", {31'd0, PCout}, 32'd1);

        // opcode sweep, with a HALT opcode parked on IR during T0
        foreach (sweep_ops[k]) begin
            IR = {5'b11001, 27'h2AB_CDEF};
            tick();
            IR = {sweep_ops[k], 27'h2AB_CDEF};
            to_t0("sweep_done");
        end

        // clear asserted mid-instruction in T4
        IR = 32'h2A2B_8000;
        repeat (4) tick();
        clear = 1'b1;
        #1;
        chk("clear_async", {6'd0, dv}, 32'h0200_0000);
        tick();
        clear = 1'b0;
        tick();
        chk("clear_restart_t0", {31'd0, PCout}, 32'd1);

        // HALT 11001
        IR = 32'hC800_0000;
        repeat (3) tick();
        chk("halt_run_low", {31'd0, run}, 32'd0);
        repeat (12) begin
            mem_ready = ~mem_ready;
            tick();
        end
        chk("halt_hold", {6'd0, dv}, 32'd0);
        clear = 1'b1;
        #1;
        chk("halt_clear_run", {31'd0, run}, 32'd1);
        tick();
        clear = 1'b0;
        mem_ready = 1'b1;
        IR = 32'h1A2B_8000;
        tick();
        chk("halt_resume_t0", {31'd0, PCout}, 32'd1);
        to_t0("resume_instr_done");

        @(negedge clock);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high; ports are named clock and clear.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 clear  input  1  asynchronous active-high reset.
REQ-004 IR  input  32  datapath IR contents: opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15].
REQ-005 mem_ready  input  1  memory read-data valid; sampled only in T1.
REQ-006 PCout  output  1  PC drives bus.
REQ-007 MARin  output  1  MAR loads bus.
REQ-008 IncPC  output  1  PC increments by 1 at clock edge.
REQ-009 Read  output  1  memory read strobe.
REQ-010 MDRin  output  1  MDR loads memory data.
REQ-011 MDRout  output  1  MDR drives bus.
REQ-012 IRin  output  1  IR loads bus.
REQ-013 gsel  output  3  one-hot {Gra,Grb,Grc} register-field select; 000 = none.
REQ-014 Rin  output  1  selected register loads bus.
REQ-015 Rout  output  1  selected register drives bus.
REQ-016 Cout  output  1  sign-extended IR[18:0] drives bus.
REQ-017 RYin  output  1  Y loads bus.
REQ-018 RZinLo  output  1  Z low loads ALU result low word.
REQ-019 RZinHi  output  1  Z high loads ALU result high word.
REQ-020 RZoutLo  output  1  Z low drives bus.
REQ-021 RZoutHi  output  1  Z high drives bus.
REQ-022 LOin  output  1  LO loads bus.
REQ-023 HIin  output  1  HI loads bus.
REQ-024 alu_op  output  5  ALU operation; equals IR[31:27] in T4, else 00000.
REQ-025 run  output  1  high in every state except HALT.

Function
REQ-026 States: RST, T0, T1, T2, T3, T4, T5, T6, HALT; 4-bit state register; outputs are combinational decode of state and IR (Moore w.r.t. state).
REQ-027 Classes: R-type 00011..01011; I-type 01100..01110; MULDIV 01111..10000; UNARY 10001..10010; NOP 11000; HALT 11001; all other opcodes execute as NOP.
REQ-028 RST: all outputs 0 except run=1; next T0.
REQ-029 T0: PCout, MARin, IncPC; next T1.
REQ-030 T1: Read, MDRin held high; stay in T1 while mem_ready=0; next T2 on edge with mem_ready=1.
REQ-031 T2: MDRout, IRin; next T0 for NOP/illegal, HALT for HALT, else T3.
REQ-032 T3: gsel=Grb, Rout, RYin; next T4.
REQ-033 T4: R-type/MULDIV gsel=Grc, Rout; I-type Cout; UNARY gsel=Grb, Rout; all assert RZinLo; MULDIV also RZinHi; next T5.
REQ-034 T5: RZoutLo plus (gsel=Gra, Rin) for non-MULDIV, LOin for MULDIV; next T0 for non-MULDIV, T6 for MULDIV.
REQ-035 T6: RZoutHi, HIin; next T0.
REQ-036 HALT: all outputs 0, run=0; held until clear.
REQ-037 At most one bus driver (PCout, MDRout, Rout, Cout, RZoutLo, RZoutHi) asserted in any state.
REQ-038 mem_ready high outside T1 SHALL be ignored; mem_ready low indefinitely keeps T1 with Read high.
REQ-039 IR changes outside T2-T6 SHALL not affect state or outputs.

Reset
REQ-040 clear high SHALL force RST immediately, mid-instruction included, with all strobes deasserted without waiting for a clock edge.
REQ-041 First rising clock after clear falls SHALL move RST -> T0.

Structure
REQ-042 Opcode class ranges, state encodings and field bit positions SHALL live in a shared package/include also used by datapath and benches.
REQ-043 One sub-module, opcode_classifier (combinational, IR[31:27] -> class), is natural; the rest is a single FSM.

Verification
REQ-044 clear pulse then IR=0x1A2B8000 (R-type 00011, ra=4, rb=5, rc=7), mem_ready=1 -> T0..T5 in 6 cycles; T4 alu_op=00011, gsel=001; T5 gsel=100, Rin=1.
REQ-045 mem_ready low 3 cycles in T1 -> Read/MDRin high 4 cycles; IRin only after mem_ready rises.
REQ-046 MULDIV opcode 01111 -> T4 RZinLo=RZinHi=1; T5 LOin; T6 HIin; next T0.
REQ-047 HALT opcode 11001 -> after T2 run=0, all outputs 0 for 10+ cycles; clear -> T0 resumes.
REQ-048 clear asserted in T4 of R-type -> outputs 0 same cycle; no Rin seen; restart T0.
REQ-049 Opcode 11111 -> T0,T1,T2 then T0; no Rin, RZinLo or gsel asserted.
